// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store memory stage with sub-word read-modify-write stores.
// Define MISALIGN_EXC_EN to flag misaligned halfword/word accesses instead of performing them.
module lsu_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        misalign,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic {IDLE, RMW_WR} state_t;
    state_t r_state, w_next;
    logic [31:0] r_addr, r_data;
    logic        w_byte, w_half, w_load, w_sw, w_mis;
    logic [4:0]  w_sh;
    logic [31:0] w_mask, w_rd_sh, w_ext, w_merged;
    assign w_byte = mem_op[1:0] == 2'b00 || mem_op == 3'b110;
    assign w_half = mem_op[1:0] == 2'b01 || mem_op == 3'b111;
    assign w_sw   = mem_op == 3'b011;
    assign w_load = !w_sw && mem_op[2:1] != 2'b11;
`ifdef MISALIGN_EXC_EN
    assign w_mis = (w_half && addr[0]) || (!w_byte && !w_half && addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif
    // Lane offset in bits; halfwords ignore addr[0], words ignore both low bits.
    assign w_sh     = w_byte ? {addr[1:0], 3'b000} : w_half ? {addr[1], 4'b0000} : 5'd0;
    assign w_mask   = (w_byte ? 32'h0000_00FF : w_half ? 32'h0000_FFFF : 32'hFFFF_FFFF) << w_sh;
    assign w_rd_sh  = mem_rdata >> w_sh;
    assign w_ext    = w_byte ? {{24{!mem_op[2] && w_rd_sh[7]}}, w_rd_sh[7:0]}
                    : w_half ? {{16{!mem_op[2] && w_rd_sh[15]}}, w_rd_sh[15:0]} : mem_rdata;
    assign w_merged = (mem_rdata & ~w_mask) | ((wdata << w_sh) & w_mask);
    always_comb begin
        w_next    = r_state;
        rdata     = 32'd0;
        done      = 1'b0;
        stall     = 1'b0;
        misalign  = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = wdata;
        if (rst) begin
            w_next = IDLE;
        end else if (r_state == RMW_WR) begin
            mem_ce    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_data;
            done      = 1'b1;
            w_next    = IDLE;
        end else if (req_valid) begin
            if (w_mis) begin
                misalign = 1'b1;
                done     = 1'b1;
            end else if (w_load) begin
                mem_ce = 1'b1;
                rdata  = w_ext;
                done   = 1'b1;
            end else if (w_sw) begin
                mem_ce = 1'b1;
                mem_we = 1'b1;
                done   = 1'b1;
            end else begin
                mem_ce = 1'b1;
                stall  = 1'b1;
                w_next = RMW_WR;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (stall) begin
                r_addr <= {addr[31:2], 2'b00};
                r_data <= w_merged;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized and directed bench against a byte-lane reference memory model.
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst, req_valid, done, stall, misalign, mem_ce, mem_we;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int checks = 0;
    int errors = 0;

    lsu_mem_stage dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .stall(stall), .misalign(misalign),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_ce && mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] op);
        return (op == 0 || op == 4 || op == 6) ? 1 : (op == 1 || op == 5 || op == 7) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] op, input logic [31:0] a);
`ifdef MISALIGN_EXC_EN
        return (a % size_of(op)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lane_of(input logic [2:0] op, input logic [31:0] a);
        int sz = size_of(op);
        return ((a % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] w = ref_mem[a[11:2]];
        int sz = size_of(op);
        longint v;
        if (sz == 4) return w;
        v = (longint'(w) >> (8 * lane_of(op, a))) % (longint'(1) << (8 * sz));
        if ((op == 0 || op == 1) && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_merge(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] b [4];
        int off = lane_of(op, a);
        int sz = size_of(op);
        for (int k = 0; k < 4; k++) begin
            b[k] = ref_mem[a[11:2]][8*k +: 8];
            if (k >= off && k < off + sz) b[k] = wd[8*(k-off) +: 8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        @(negedge clk);
        req_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
        #1;
        if (is_mis(op, a)) begin
            check("mis_flag", misalign, 1); check("mis_done", done, 1);
            check("mis_ce", mem_ce, 0); check("mis_rdata", rdata, 0);
            return;
        end
        check("misalign0", misalign, 0);
        check("ce", mem_ce, 1);
        check("maddr", mem_addr, {a[31:2], 2'b00});
        if (op == 3'b011) begin
            check("sw_we", mem_we, 1); check("sw_done", done, 1);
            check("sw_stall", stall, 0); check("sw_wdata", mem_wdata, wd);
            ref_mem[a[11:2]] = wd;
        end else if (op == 3'b110 || op == 3'b111) begin
            check("rmw_rd_we", mem_we, 0); check("rmw_stall", stall, 1); check("rmw_done0", done, 0);
            m = ref_merge(op, a, wd);
            @(negedge clk);
            req_valid = 1'($urandom); mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
            #1;
            check("rmw_wr_we", mem_we, 1); check("rmw_wr_ce", mem_ce, 1);
            check("rmw_wr_done", done, 1); check("rmw_wr_stall", stall, 0);
            check("rmw_wr_addr", mem_addr, {a[31:2], 2'b00}); check("rmw_wr_data", mem_wdata, m);
            ref_mem[a[11:2]] = m;
        end else begin
            check("ld_we", mem_we, 0); check("ld_done", done, 1); check("ld_stall", stall, 0);
            check("ld_rdata", rdata, ref_load(op, a));
        end
    endtask

    task automatic do_idle();
        @(negedge clk);
        req_valid = 1'b0; mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
        #1;
        check("idle_ce", mem_ce, 0); check("idle_we", mem_we, 0); check("idle_rdata", rdata, 0);
        check("idle_done", done, 0); check("idle_stall", stall, 0);
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        int bad;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        set_word(32'h80 >> 2, 32'h12345678);
        set_word(32'hA0 >> 2, 32'h000000F0);
        set_word(32'h40 >> 2, 32'hAABBCCDD);
        rst = 1'b1; req_valid = 1'b1; mem_op = 3'b110; addr = 32'h41; wdata = 32'h11;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ce", mem_ce, 0); check("rst_we", mem_we, 0); check("rst_done", done, 0);
        check("rst_stall", stall, 0); check("rst_rdata", rdata, 0); check("rst_mis", misalign, 0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;

        do_req(3'b000, 32'h83, 0); check("lb83", rdata, 32'h00000012);
        do_req(3'b001, 32'h80, 0); check("lh80", rdata, 32'h00005678);
        do_req(3'b000, 32'hA0, 0); check("lbA0", rdata, 32'hFFFFFFF0);
        do_req(3'b100, 32'hA0, 0); check("lbuA0", rdata, 32'h000000F0);
        do_idle();

        do_req(3'b110, 32'h41, 32'h11);
        do_req(3'b010, 32'h40, 0); check("sb_result", rdata, 32'hAABB11DD);

        set_word(32'h40 >> 2, 32'hAABBCCDD);
        do_req(3'b111, 32'h42, 32'hBEEF);
        do_req(3'b010, 32'h40, 0); check("sh_b2b", rdata, 32'hBEEFCCDD);

        @(negedge clk);
        set_word(32'h40 >> 2, 32'hAABBCCDD);
        req_valid = 1'b1; mem_op = 3'b110; addr = 32'h41; wdata = 32'h11;
        #1; check("rstrmw_stall", stall, 1);
        @(negedge clk);
        rst = 1'b1;
        #1; check("rstrmw_we", mem_we, 0); check("rstrmw_ce", mem_ce, 0); check("rstrmw_done", done, 0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1; check("rstrmw_stall_after", stall, 0); check("rstrmw_we_after", mem_we, 0);
        do_req(3'b010, 32'h40, 0); check("rstrmw_unchanged", rdata, 32'hAABBCCDD);

        do_req(3'b010, 32'h42, 0);
`ifdef MISALIGN_EXC_EN
        check("lw42_mis", misalign, 1); check("lw42_ce", mem_ce, 0);
`else
        check("lw42_word", rdata, 32'hAABBCCDD); check("lw42_nomis", misalign, 0);
`endif

        for (int n = 0; n < 400; n++) begin
            a = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 7) == 0) do_idle();
            else do_req(3'($urandom), a, $urandom);
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_sweep", bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
